// File: rtl/booth_div_radix2.sv
// Sequential signed restoring divider, one quotient bit per clock.
// Sign-magnitude pre/post correction; quotient truncates toward zero, remainder follows the dividend's sign.
module booth_div_radix2 #(
    parameter int unsigned WIDTH_N = 8,
    parameter int unsigned WIDTH_D = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               vld_in,
    input  logic [WIDTH_N-1:0] dividend,
    input  logic [WIDTH_D-1:0] divisor,
    output logic               busy,
    output logic [WIDTH_N-1:0] quotient,
    output logic [WIDTH_D-1:0] remainder,
    output logic               div_zero,
    output logic               ovf,
    output logic               done
);

    localparam int unsigned CNT_W = (WIDTH_N > 2) ? $clog2(WIDTH_N) : 1;
    localparam int unsigned PR_W  = WIDTH_D + 1;
    localparam int unsigned EXT_W = WIDTH_N + WIDTH_D;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH_N-1:0] dvd_q, dvd_d;
    logic [WIDTH_D-1:0] dvs_q, dvs_d;
    logic [WIDTH_D-1:0] absd_q, absd_d;
    logic [PR_W-1:0]    pr_q, pr_d;
    logic [WIDTH_N-1:0] qr_q, qr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dz_int_q, dz_int_d;
    logic               ovf_int_q, ovf_int_d;
    logic [WIDTH_N-1:0] quotient_q, quotient_d;
    logic [WIDTH_D-1:0] remainder_q, remainder_d;
    logic               div_zero_q, div_zero_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               sign_n, sign_d;
    logic [PR_W-1:0]    pr_sh, diff;
    logic [WIDTH_N-1:0] q_fix;
    logic [WIDTH_D-1:0] r_fix;
    logic [EXT_W-1:0]   dvd_ext;

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        absd_d      = absd_q;
        pr_d        = pr_q;
        qr_d        = qr_q;
        cnt_d       = cnt_q;
        dz_int_d    = dz_int_q;
        ovf_int_d   = ovf_int_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
        busy_d      = busy_q;

        sign_n  = dvd_q[WIDTH_N-1];
        sign_d  = dvs_q[WIDTH_D-1];
        pr_sh   = {pr_q[WIDTH_D-1:0], qr_q[WIDTH_N-1]};
        diff    = pr_sh - {1'b0, absd_q};
        q_fix   = (sign_n ^ sign_d) ? (WIDTH_N'(0) - qr_q) : qr_q;
        r_fix   = sign_n ? (WIDTH_D'(0) - pr_q[WIDTH_D-1:0]) : pr_q[WIDTH_D-1:0];
        dvd_ext = {{WIDTH_D{sign_n}}, dvd_q};

        case (state_q)
            IDLE: begin
                if (vld_in) begin
                    state_d = LOAD;
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                qr_d      = sign_n ? (WIDTH_N'(0) - dvd_q) : dvd_q;
                absd_d    = sign_d ? (WIDTH_D'(0) - dvs_q) : dvs_q;
                pr_d      = '0;
                cnt_d     = '0;
                dz_int_d  = (dvs_q == '0);
                ovf_int_d = (dvd_q == {1'b1, {(WIDTH_N-1){1'b0}}}) && (dvs_q == '1);
                state_d   = DIV;
            end
            DIV: begin
                // Restoring step: keep the difference only when it did not go negative.
                if (!diff[PR_W-1]) begin
                    pr_d = diff;
                    qr_d = {qr_q[WIDTH_N-2:0], 1'b1};
                end else begin
                    pr_d = pr_sh;
                    qr_d = {qr_q[WIDTH_N-2:0], 1'b0};
                end
                if (cnt_q == CNT_W'(WIDTH_N - 1)) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIX: begin
                if (dz_int_q) begin
                    quotient_d  = '1;
                    remainder_d = dvd_ext[WIDTH_D-1:0];
                end else if (ovf_int_q) begin
                    quotient_d  = {1'b1, {(WIDTH_N-1){1'b0}}};
                    remainder_d = '0;
                end else begin
                    quotient_d  = q_fix;
                    remainder_d = r_fix;
                end
                div_zero_d = dz_int_q;
                ovf_d      = ovf_int_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            absd_q      <= '0;
            pr_q        <= '0;
            qr_q        <= '0;
            cnt_q       <= '0;
            dz_int_q    <= 1'b0;
            ovf_int_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            absd_q      <= absd_d;
            pr_q        <= pr_d;
            qr_q        <= qr_d;
            cnt_q       <= cnt_d;
            dz_int_q    <= dz_int_d;
            ovf_int_q   <= ovf_int_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign ovf       = ovf_q;
    assign done      = done_q;

endmodule

// File: tb/tb_booth_div_radix2.sv
// Bench for booth_div_radix2 (8/8): directed corners, randomized ops, back-to-back, mid-op reset.
module tb_booth_div_radix2;

    logic       clk;
    logic       rstn;
    logic       vld_in;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_zero;
    logic       ovf;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    booth_div_radix2 #(.WIDTH_N(8), .WIDTH_D(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .vld_in    (vld_in),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed integer division with the defined special cases.
    function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] q, output logic [7:0] r,
                                    output logic dz, output logic ov);
        int n;
        int d;
        n  = int'($signed(a));
        d  = int'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        if (d == 0) begin
            q  = 8'hFF;
            r  = a;
            dz = 1'b1;
        end else if (n == -128 && d == -1) begin
            q  = 8'h80;
            r  = 8'h00;
            ov = 1'b1;
        end else begin
            q = 8'(n / d);
            r = 8'(n % d);
        end
    endfunction

    task automatic check_result(input string tag, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] eq;
        logic [7:0] er;
        logic       edz;
        logic       eov;
        ref_div(a, b, eq, er, edz, eov);
        chk({tag, ".done"}, 16'(done), 16'd1);
        chk({tag, ".busy"}, 16'(busy), 16'd0);
        chk({tag, ".quot"}, 16'(quotient), 16'(eq));
        chk({tag, ".rem"}, 16'(remainder), 16'(er));
        chk({tag, ".dz"}, 16'(div_zero), 16'(edz));
        chk({tag, ".ovf"}, 16'(ovf), 16'(eov));
    endtask

    // Waits for done after the accepting edge, returning the number of edges taken.
    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b);
        int edges;
        @(negedge clk);
        vld_in   = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        vld_in   = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        chk({tag, ".busy_start"}, 16'(busy), 16'd1);
        wait_done(edges);
        chk({tag, ".latency"}, 16'(edges), 16'd10);
        check_result(tag, a, b);
        @(posedge clk);
        #1;
        chk({tag, ".done_pulse"}, 16'(done), 16'd0);
    endtask

    initial begin
        int         edges;
        int         seen;
        logic [7:0] ra;
        logic [7:0] rb;

        rstn     = 1'b0;
        vld_in   = 1'b0;
        dividend = 8'h00;
        divisor  = 8'h00;
        #12;
        chk("rst.quot", 16'(quotient), 16'h0);
        chk("rst.rem", 16'(remainder), 16'h0);
        chk("rst.flags", 16'({div_zero, ovf, done, busy}), 16'h0);
        @(negedge clk);
        rstn = 1'b1;

        do_op("p100_7", 8'd100, 8'd7);
        do_op("m100_7", 8'h9C, 8'd7);
        do_op("p100_m7", 8'd100, 8'hF9);
        do_op("m100_m7", 8'h9C, 8'hF9);
        do_op("m128_m1", 8'h80, 8'hFF);
        do_op("m128_p1", 8'h80, 8'h01);
        do_op("p7_100", 8'd7, 8'd100);
        do_op("p5_0", 8'd5, 8'd0);
        do_op("p9_3", 8'd9, 8'd3);
        do_op("m5_0", 8'hFB, 8'd0);
        do_op("m128_m128", 8'h80, 8'h80);
        do_op("p127_m128", 8'h7F, 8'h80);
        do_op("zero_m3", 8'h00, 8'hFD);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 7))
                0: rb = 8'h00;
                1: rb = 8'hFF;
                2: ra = 8'h80;
                3: rb = 8'h80;
                default: ;
            endcase
            do_op($sformatf("rnd%0d", i), ra, rb);
        end

        // vld_in held high across two operations with operands changing mid-op.
        @(negedge clk);
        vld_in   = 1'b1;
        dividend = 8'd10;
        divisor  = 8'd3;
        @(posedge clk);
        #1;
        dividend = 8'd77;
        divisor  = 8'd5;
        repeat (4) @(posedge clk);
        #1;
        dividend = 8'hF7;
        divisor  = 8'd2;
        wait_done(edges);
        edges = edges + 4;
        chk("b2b1.latency", 16'(edges), 16'd10);
        check_result("b2b1", 8'd10, 8'd3);
        @(posedge clk);
        #1;
        vld_in = 1'b0;
        chk("b2b2.busy_start", 16'(busy), 16'd1);
        wait_done(edges);
        chk("b2b.spacing", 16'(edges + 1), 16'd11);
        check_result("b2b2", 8'hF7, 8'd2);

        // Reset during the fifth DIV iteration must clear outputs and suppress done.
        @(negedge clk);
        vld_in   = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(posedge clk);
        #1;
        vld_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("mid_rst.quot", 16'(quotient), 16'h0);
        chk("mid_rst.rem", 16'(remainder), 16'h0);
        chk("mid_rst.flags", 16'({div_zero, ovf, done, busy}), 16'h0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen++;
        end
        rstn = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("mid_rst.no_done", 16'(seen), 16'd0);
        do_op("p50_5", 8'd50, 8'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
